// File: rtl/memory_stage.sv
// MEM stage: registers Execute results, performs LOAD/STORE on a req/ack
// data-memory port, stalls upstream while an access is outstanding, and
// presents a one-cycle-valid writeback bundle.
module memory_stage #(
  parameter int unsigned DATA_W   = 16,
  parameter logic [4:0]  OP_LOAD  = 5'b01000,
  parameter logic [4:0]  OP_STORE = 5'b01001,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [4:0]        control_in,
  input  logic [4:0]        dest_index_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              reg_write_en_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_control,
  output logic [4:0]        wb_dest_index,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_reg_write_en,
  output logic              mem_error
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   count, count_d;
  logic [4:0]         op_q, op_d;
  logic [4:0]         dest_q, dest_d;
  logic               lwe_q, lwe_d;
  logic               req_d, we_d, wbv_d, wbwe_d, err_d;
  logic [DATA_W-1:0]  addr_d, wdata_d, wbdata_d;
  logic [4:0]         wbc_d, wbdst_d;
  logic               is_mem_op;

  assign is_mem_op = (control_in == OP_LOAD) || (control_in == OP_STORE);
  assign stall_out = (state == BUSY);

  // State and registered outputs; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      count           <= '0;
      op_q            <= '0;
      dest_q          <= '0;
      lwe_q           <= 1'b0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      wb_valid        <= 1'b0;
      wb_control      <= '0;
      wb_dest_index   <= '0;
      wb_data         <= '0;
      wb_reg_write_en <= 1'b0;
      mem_error       <= 1'b0;
    end else begin
      state           <= state_d;
      count           <= count_d;
      op_q            <= op_d;
      dest_q          <= dest_d;
      lwe_q           <= lwe_d;
      mem_req         <= req_d;
      mem_we          <= we_d;
      mem_addr        <= addr_d;
      mem_wdata       <= wdata_d;
      wb_valid        <= wbv_d;
      wb_control      <= wbc_d;
      wb_dest_index   <= wbdst_d;
      wb_data         <= wbdata_d;
      wb_reg_write_en <= wbwe_d;
      mem_error       <= err_d;
    end
  end

  // Next-state and next-output logic; wb_valid/mem_error default low so they pulse.
  always_comb begin
    state_d  = state;
    count_d  = count;
    op_d     = op_q;
    dest_d   = dest_q;
    lwe_d    = lwe_q;
    req_d    = mem_req;
    we_d     = mem_we;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    wbv_d    = 1'b0;
    wbc_d    = wb_control;
    wbdst_d  = wb_dest_index;
    wbdata_d = wb_data;
    wbwe_d   = wb_reg_write_en;
    err_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_in) begin
          if (is_mem_op) begin
            op_d    = control_in;
            dest_d  = dest_index_in;
            lwe_d   = reg_write_en_in;
            addr_d  = result_in;
            wdata_d = store_data_in;
            we_d    = (control_in == OP_STORE);
            req_d   = 1'b1;
            count_d = '0;
            state_d = BUSY;
          end else begin
            wbv_d    = 1'b1;
            wbc_d    = control_in;
            wbdst_d  = dest_index_in;
            wbdata_d = result_in;
            wbwe_d   = reg_write_en_in;
          end
        end
      end
      BUSY: begin
        // Ack is tested before the timeout so a same-edge ack completes normally.
        if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wbv_d   = 1'b1;
          wbc_d   = op_q;
          wbdst_d = dest_q;
          if (op_q == OP_STORE) begin
            wbdata_d = mem_addr;
            wbwe_d   = 1'b0;
          end else begin
            wbdata_d = mem_rdata;
            wbwe_d   = lwe_q;
          end
          state_d = IDLE;
        end else if (count == CNT_W'(TIMEOUT - 1)) begin
          req_d    = 1'b0;
          we_d     = 1'b0;
          err_d    = 1'b1;
          wbv_d    = 1'b1;
          wbc_d    = op_q;
          wbdst_d  = dest_q;
          wbwe_d   = 1'b0;
          wbdata_d = '0;
          state_d  = IDLE;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
